// File: rtl/nibble_serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if
//
// Purpose:
//   Groups the operand handshake (requester side) and the result handshake
//   (consumer side) of the nibble-serial adder into one bundle.
//
// Signals:
//   in_valid  requester -> adder   operands a, b, cin are valid
//   in_ready  adder -> requester   adder can accept operands
//   a, b      requester -> adder   WIDTH-bit operands
//   cin       requester -> adder   carry into the least-significant nibble
//   sub       requester -> adder   subtract request (only with
//                                  NIBBLE_ADDER_SUB_EN defined)
//   out_valid adder -> consumer    result valid
//   out_ready consumer -> adder    consumer accepts the result
//   s         adder -> consumer    WIDTH-bit sum
//   cout      adder -> consumer    carry out of the most-significant nibble
//   busy      adder -> observer    high while nibbles are being processed
//
// Modports:
//   master  used by the requester/consumer side (the testbench)
//   slave   used by nibble_serial_adder_ctrl
//
// Configuration macro: NIBBLE_ADDER_SUB_EN adds the sub signal.
// ---------------------------------------------------------------------------
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;
`ifdef NIBBLE_ADDER_SUB_EN
    logic             sub;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, busy
    );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose:
//   Adds two WIDTH-bit operands by time-sharing a single 4-bit ripple-carry
//   adder, one nibble per clock, least-significant nibble first. The carry
//   between nibbles lives in a carry register. Operands arrive over a
//   valid/ready handshake and the result leaves over a second valid/ready
//   handshake. Latency is NIBBLES edges from accept to out_valid; one
//   operation takes at least NIBBLES+2 cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (priority over everything)
//   bus    nibble_serial_adder_ctrl_if.slave:
//            in_valid/in_ready, a, b, cin  operand handshake
//            out_valid/out_ready, s, cout  result handshake
//            busy                          high while in BUSY
//
// Parameters:
//   WIDTH  operand/result width, multiple of 4 and at least 4
//
// Configuration macro:
//   NIBBLE_ADDER_SUB_EN  when defined, bus.sub is latched on accept; sub=1
//                        computes a - b by inverting B nibbles and forcing
//                        the initial carry to 1 (cout=1 means no borrow).
// ---------------------------------------------------------------------------

// The lab's two-by-two 4-bit adder: two chained 2-bit ripple sections.
module nibble_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [2:0] lo_sum;
    logic [2:0] hi_sum;

    // Lower pair of bits, then the upper pair fed by the lower pair's carry.
    always_comb begin
        lo_sum = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
        hi_sum = {1'b0, a[3:2]} + {1'b0, b[3:2]} + {2'b00, lo_sum[2]};
    end

    assign sum = {hi_sum[1:0], lo_sum[1:0]};
    assign co  = hi_sum[2];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               carry_q,     carry_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [WIDTH-1:0]   s_q,         s_d;
    logic               cout_q,      cout_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic               busy_q,      busy_d;
`ifdef NIBBLE_ADDER_SUB_EN
    logic               sub_q,       sub_d;
`endif

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         nib_sum;
    logic               nib_co;
    logic [IDX_W+1:0]   nib_base;

    // Bit offset of the nibble currently being processed.
    assign nib_base = {idx_q, 2'b00};

    // Select the current operand nibbles; subtraction inverts B here so the
    // shared adder only ever adds.
    always_comb begin
        a_nib = a_q[nib_base +: 4];
        b_nib = b_q[nib_base +: 4];
`ifdef NIBBLE_ADDER_SUB_EN
        if (sub_q) begin
            b_nib = ~b_q[nib_base +: 4];
        end
`endif
    end

    nibble_adder4 u_adder (
        .a   (a_nib),
        .b   (b_nib),
        .ci  (carry_q),
        .sum (nib_sum),
        .co  (nib_co)
    );

    // Next-state and next-output logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
`ifdef NIBBLE_ADDER_SUB_EN
        sub_d       = sub_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
`ifdef NIBBLE_ADDER_SUB_EN
                    sub_d      = bus.sub;
                    carry_d    = bus.sub ? 1'b1 : bus.cin;
`else
                    carry_d    = bus.cin;
`endif
                    idx_d      = '0;
                    s_d        = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_BUSY;
                end
            end

            S_BUSY: begin
                s_d[nib_base +: 4] = nib_sum;
                carry_d            = nib_co;
                if (idx_q == LAST_IDX) begin
                    cout_d      = nib_co;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    idx_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef NIBBLE_ADDER_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Purpose:
//   Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16). A
//   transaction-level model (whole-word arithmetic plus a countdown of busy
//   cycles) predicts every output each cycle; directed operations also pin
//   literal results and the accept-to-valid latency. A random phase drives
//   operands, handshakes and occasional resets.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state, updated on each rising edge from the sampled inputs.
    logic             modelEn   = 1'b0;
    logic             expReady  = 1'b1;
    logic             expValid  = 1'b0;
    logic             expBusy   = 1'b0;
    logic [WIDTH-1:0] expS      = '0;
    logic             expCout   = 1'b0;
    logic [WIDTH:0]   result    = '0;
    int               busyLeft  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Low 4*n bits of the pending result: what s must show after n nibbles.
    function automatic logic [WIDTH-1:0] partial(input logic [WIDTH:0] r, input int n);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < 4 * n; i++) m[i] = 1'b1;
        return r[WIDTH-1:0] & m;
    endfunction

    // Behavioural reference model.
    always @(posedge clk) begin
        logic doSub;
        doSub = 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
        doSub = bus.sub;
`endif
        modelEn = 1'b1;
        if (reset) begin
            expReady = 1'b1;
            expValid = 1'b0;
            expBusy  = 1'b0;
            expS     = '0;
            expCout  = 1'b0;
            busyLeft = 0;
        end else if (expReady && bus.in_valid) begin
            if (doSub)
                result = {1'b0, bus.a} + {1'b0, ~bus.b} + 17'd1;
            else
                result = {1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.cin};
            expReady = 1'b0;
            expBusy  = 1'b1;
            expS     = '0;
            busyLeft = NIBBLES;
        end else if (expBusy) begin
            busyLeft--;
            expS = partial(result, NIBBLES - busyLeft);
            if (busyLeft == 0) begin
                expBusy  = 1'b0;
                expValid = 1'b1;
                expCout  = result[WIDTH];
            end
        end else if (expValid && bus.out_ready) begin
            expValid = 1'b0;
            expReady = 1'b1;
        end
    end

    // Compare process: every cycle, shortly after the rising edge.
    always @(posedge clk) begin
        #1;
        if (modelEn) begin
            checkOutput("in_ready",  {31'd0, bus.in_ready},  {31'd0, expReady});
            checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, expValid});
            checkOutput("busy",      {31'd0, bus.busy},      {31'd0, expBusy});
            checkOutput("s",         {16'd0, bus.s},         {16'd0, expS});
            checkOutput("cout",      {31'd0, bus.cout},      {31'd0, expCout});
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic ci, input logic sb);
        bus.a        = opA;
        bus.b        = opB;
        bus.cin      = ci;
`ifdef NIBBLE_ADDER_SUB_EN
        bus.sub      = sb;
`else
        if (sb) $display("[TB] note: sub requested without NIBBLE_ADDER_SUB_EN");
`endif
        bus.in_valid = 1'b1;
    endtask

    // One directed operation: wait for ready, accept, measure latency, hold
    // the result under backpressure for holdCycles, then release it.
    task automatic doOp(input string name, input logic [WIDTH-1:0] opA,
                        input logic [WIDTH-1:0] opB, input logic ci, input logic sb,
                        input int holdCycles, input logic [WIDTH-1:0] wantS,
                        input logic wantCout);
        int guard;
        int lat;
        bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
        applyStimulus(opA, opB, ci, sb);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (holdCycles > 0) bus.in_valid = lat[0];
        end while (!bus.out_valid && lat < 20);
        checkOutput({name, "_latency"}, lat, NIBBLES);
        checkOutput({name, "_s"},    {16'd0, bus.s},    {16'd0, wantS});
        checkOutput({name, "_cout"}, {31'd0, bus.cout}, {31'd0, wantCout});
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            @(posedge clk);
            #1;
            checkOutput({name, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            checkOutput({name, "_hold_ready"}, {31'd0, bus.in_ready},  32'd0);
            checkOutput({name, "_hold_s"},     {16'd0, bus.s},         {16'd0, wantS});
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, "_release_ready"}, {31'd0, bus.in_ready},  32'd1);
        checkOutput({name, "_release_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // Global time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("reset_s",         {16'd0, bus.s},         32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed operations");
        doOp("add_5555",  16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0);
        doOp("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1);
        doOp("cin_only",  16'h0000, 16'h0000, 1'b1, 1'b0, 0, 16'h0001, 1'b0);
        doOp("backpress", 16'h00FF, 16'h0001, 1'b0, 1'b0, 3, 16'h0100, 1'b0);

        $display("[TB] reset during BUSY");
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midreset_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("midreset_s",         {16'd0, bus.s},         32'd0);
        checkOutput("midreset_cout",      {31'd0, bus.cout},      32'd0);
        @(negedge clk);
        reset = 1'b0;
        doOp("after_reset", 16'h0002, 16'h0003, 1'b0, 1'b0, 0, 16'h0005, 1'b0);

        $display("[TB] back-to-back with in_valid held");
        bus.out_ready = 1'b1;
        applyStimulus(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!bus.out_valid && guard < 20);
        checkOutput("b2b_first_s",    {16'd0, bus.s},    32'h0001);
        checkOutput("b2b_first_cout", {31'd0, bus.cout}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_ready_back", {31'd0, bus.in_ready}, 32'd1);
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!bus.out_valid && guard < 20);
        checkOutput("b2b_second_lat",  guard, NIBBLES + 1);
        checkOutput("b2b_second_s",    {16'd0, bus.s},    32'h0002);
        checkOutput("b2b_second_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;

`ifdef NIBBLE_ADDER_SUB_EN
        $display("[TB] subtraction");
        doOp("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0);
        doOp("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1);
`endif

        $display("[TB] random phase");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset         = ($urandom_range(0, 199) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            bus.a         = WIDTH'($urandom);
            bus.b         = WIDTH'($urandom);
            bus.cin       = 1'($urandom);
`ifdef NIBBLE_ADDER_SUB_EN
            bus.sub       = 1'($urandom);
`endif
        end
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that time-shares one 4-bit ripple-carry adder (the existing two-by-two 4-bit adder, instantiated once inside this block) to add WIDTH-bit operands, one nibble per clock, least-significant nibble first.
- Carries between nibbles through a carry register.
- Sits between a requester (valid/ready operand handshake) and a consumer (valid/ready result handshake).
- Trades latency for area in the lab datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4 is derived.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into the least-significant nibble
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- s  output  WIDTH  sum
- cout  output  1  carry out of the most-significant nibble
- busy  output  1  high while in the BUSY state

Behaviour:
- One clock; reset is synchronous and active-high; all state changes on the rising edge of clk.
- States: IDLE, BUSY, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, carry register=0, nibble index=0.
- Reset has priority over every other event, including mid-BUSY and mid-DONE. A partial result is discarded.
- IDLE:
  - in_ready=1.
  - An edge with in_valid=1 is an accept edge: latch a, b into operand registers, load carry register with cin, set nibble index=0, clear s to 0, go to BUSY.
  - With in_valid=0, stay in IDLE.
- BUSY:
  - in_ready=0 and busy=1; in_valid is ignored.
  - Each edge feeds nibble[idx] of A and B plus the carry register to the adder.
  - The adder's 4-bit sum is written to s[4*idx+3 : 4*idx].
  - The adder's carry out is written to the carry register, and idx increments.
  - On the edge that processes idx=NIBBLES-1: cout takes the final carry, out_valid goes to 1, busy goes to 0, and state goes to DONE.
- Latency: out_valid rises exactly NIBBLES edges after the accept edge (4 for WIDTH=16).
- DONE:
  - out_valid=1 and in_ready=0.
  - s and cout are held stable while out_ready=0; there is no timeout.
  - An edge with out_ready=1 clears out_valid and returns to IDLE, so in_ready=1 in the following cycle.
  - s and cout keep their last values in IDLE until the next accept edge.
- Arithmetic:
  - Result is modulo 2^WIDTH: {cout, s} = a + b + cin.
  - Intermediate s nibbles are visible during BUSY but are only valid while out_valid=1.
- Throughput: one operation per NIBBLES+2 cycles minimum (accept, NIBBLES busy cycles, result handshake).
- No overlap of a new accept with a pending result.

Optional Feature:
- Macro: NIBBLE_ADDER_SUB_EN.
- When defined:
  - Add input port sub (1 bit), latched on the accept edge.
  - If sub=1, B is inverted nibble-by-nibble before the adder, and the carry register is loaded with 1 (cin is ignored).
  - Result is s = a - b mod 2^WIDTH; cout = 1 means no borrow.
  - If sub=0, behaviour is identical to the undefined case.
- When undefined: no sub port; addition only.

Test Plan:
- Reset, then accept a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 edges after accept; s=0x5555, cout=0; busy high for those 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all nibbles; s=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> s=0x0001, cout=0.
- Backpressure: result 0x00FF+0x0001 with out_ready held 0 for 3 cycles -> s=0x0100, cout=0 stable, out_valid=1, in_ready=0 throughout; in_valid pulses during BUSY/DONE are ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset asserted after 2 BUSY edges of a=0xABCD, b=0x1111 -> next cycle state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, busy=0; a following op 0x0002+0x0003 yields s=0x0005.
- Back-to-back: two ops issued with in_valid held high -> second accepted on the first cycle in_ready returns to 1; each result correct and independent of the previous carry.
- With NIBBLE_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0; sub=1, a=0x0007, b=0x0005 -> s=0x0002, cout=1.
